// File: rtl/sudoku_game_fsm.sv
// Sudoku game controller: screen sequencing, 9x9 grid storage, board cursor and digit entry.
// One button action per cycle, chosen a > b > start > up > down > left > right; outputs registered.
module sudoku_game_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_button,
   input  logic       a_button,
   input  logic       b_button,
   input  logic       up_button,
   input  logic       down_button,
   input  logic       left_button,
   input  logic       right_button,
   output logic [2:0] current_state,
   output logic       title_display,
   output logic       difficulty_display,
   output logic       running_display,
   output logic       easy_selected,
   output logic       hard_selected,
   output logic [3:0] cursor_x,
   output logic [3:0] cursor_y
);

   typedef enum logic [2:0] {
      S_TITLE  = 3'b000,
      S_SELECT = 3'b001,
      S_LOAD   = 3'b010,
      S_MAP    = 3'b011,
      S_DIGIT  = 3'b100,
      S_WIN    = 3'b101
   } state_t;

   typedef enum logic [2:0] {
      BTN_NONE, BTN_A, BTN_B, BTN_START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT
   } btn_t;

   state_t     state_q, state_d;
   logic       easy_q, easy_d;
   logic [3:0] cx_q, cx_d;
   logic [3:0] cy_q, cy_d;
   logic [3:0] digit_q, digit_d;
   logic       title_q, select_q, running_q;
   logic       grid_clr, grid_wr;
   btn_t       btn;
   logic       solved;
   logic [3:0] cur_cell;

   logic [3:0] cell_value [0:8][0:8];

   logic [8:0] row_m [0:8];
   logic [8:0] col_m [0:8];
   logic [8:0] box_m [0:8];

   // Values outside 1..9 map to no bit, so an invalid cell can never complete a group.
   function automatic logic [8:0] digit_bit(input logic [3:0] v);
      logic [8:0] r;
      r = '0;
      for (int k = 1; k <= 9; k++) begin
         if (v == 4'(k)) r[k-1] = 1'b1;
      end
      return r;
   endfunction

   always_comb begin
      btn = BTN_NONE;
      if (a_button)          btn = BTN_A;
      else if (b_button)     btn = BTN_B;
      else if (start_button) btn = BTN_START;
      else if (up_button)    btn = BTN_UP;
      else if (down_button)  btn = BTN_DOWN;
      else if (left_button)  btn = BTN_LEFT;
      else if (right_button) btn = BTN_RIGHT;
   end

   // Nine cells per group all landing on distinct bits means 1..9 with no repeats.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         row_m[i] = '0;
         col_m[i] = '0;
         box_m[i] = '0;
      end
      for (int x = 0; x < 9; x++) begin
         for (int y = 0; y < 9; y++) begin
            row_m[4'(y)] = row_m[4'(y)] | digit_bit(cell_value[4'(x)][4'(y)]);
            col_m[4'(x)] = col_m[4'(x)] | digit_bit(cell_value[4'(x)][4'(y)]);
            box_m[4'((x / 3) * 3 + y / 3)] = box_m[4'((x / 3) * 3 + y / 3)]
                                           | digit_bit(cell_value[4'(x)][4'(y)]);
         end
      end
      solved = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (row_m[i] != 9'h1FF || col_m[i] != 9'h1FF || box_m[i] != 9'h1FF) solved = 1'b0;
      end
   end

   assign cur_cell = cell_value[cx_q][cy_q];

   always_comb begin
      state_d  = state_q;
      easy_d   = easy_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      digit_d  = digit_q;
      grid_clr = 1'b0;
      grid_wr  = 1'b0;
      case (state_q)
         S_TITLE: begin
            if (btn == BTN_START) state_d = S_SELECT;
         end
         S_SELECT: begin
            case (btn)
               BTN_UP:   easy_d  = 1'b1;
               BTN_DOWN: easy_d  = 1'b0;
               BTN_A:    state_d = S_LOAD;
               default: ;
            endcase
         end
         S_LOAD: begin
            grid_clr = 1'b1;
            cx_d     = 4'd4;
            cy_d     = 4'd4;
            state_d  = S_MAP;
         end
         S_MAP: begin
            case (btn)
               BTN_UP:    cy_d = (cy_q == 4'd0) ? 4'd8 : cy_q - 4'd1;
               BTN_DOWN:  cy_d = (cy_q >= 4'd8) ? 4'd0 : cy_q + 4'd1;
               BTN_LEFT:  cx_d = (cx_q == 4'd0) ? 4'd8 : cx_q - 4'd1;
               BTN_RIGHT: cx_d = (cx_q >= 4'd8) ? 4'd0 : cx_q + 4'd1;
               BTN_A: begin
                  digit_d = cur_cell;
                  state_d = S_DIGIT;
               end
               BTN_START: if (solved) state_d = S_WIN;
               default: ;
            endcase
         end
         S_DIGIT: begin
            case (btn)
               BTN_UP:   digit_d = (digit_q >= 4'd9) ? 4'd1 : digit_q + 4'd1;
               BTN_DOWN: digit_d = (digit_q <= 4'd1) ? 4'd9 : digit_q - 4'd1;
               BTN_A: begin
                  grid_wr = 1'b1;
                  state_d = S_MAP;
               end
               BTN_B:    state_d = S_MAP;
               default: ;
            endcase
         end
         S_WIN: begin
            if (btn == BTN_START) state_d = S_TITLE;
         end
         default: state_d = S_TITLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_TITLE;
         easy_q    <= 1'b1;
         cx_q      <= 4'd4;
         cy_q      <= 4'd4;
         digit_q   <= 4'd0;
         title_q   <= 1'b1;
         select_q  <= 1'b0;
         running_q <= 1'b0;
         for (int x = 0; x < 9; x++) begin
            for (int y = 0; y < 9; y++) cell_value[x][y] <= 4'd0;
         end
      end else begin
         state_q   <= state_d;
         easy_q    <= easy_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         digit_q   <= digit_d;
         title_q   <= (state_d == S_TITLE);
         select_q  <= (state_d == S_SELECT);
         running_q <= (state_d == S_LOAD) || (state_d == S_MAP) || (state_d == S_DIGIT);
         if (grid_clr) begin
            for (int x = 0; x < 9; x++) begin
               for (int y = 0; y < 9; y++) cell_value[x][y] <= 4'd0;
            end
         end else if (grid_wr) begin
            cell_value[cx_q][cy_q] <= digit_q;
         end
      end
   end

   assign current_state      = state_q;
   assign title_display      = title_q;
   assign difficulty_display = select_q;
   assign running_display    = running_q;
   assign easy_selected      = easy_q;
   assign hard_selected      = ~easy_q;
   assign cursor_x           = cx_q;
   assign cursor_y           = cy_q;

endmodule

// File: tb/tb_sudoku_game_fsm.sv
// Bench for sudoku_game_fsm: scenario tasks push expected state/cursor per button step and compare on output.
module tb_sudoku_game_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_button = 1'b0, a_button = 1'b0, b_button = 1'b0;
   logic       up_button = 1'b0, down_button = 1'b0, left_button = 1'b0, right_button = 1'b0;
   logic [2:0] current_state;
   logic       title_display, difficulty_display, running_display;
   logic       easy_selected, hard_selected;
   logic [3:0] cursor_x, cursor_y;

   sudoku_game_fsm dut (
      .clk(clk), .reset(reset),
      .start_button(start_button), .a_button(a_button), .b_button(b_button),
      .up_button(up_button), .down_button(down_button),
      .left_button(left_button), .right_button(right_button),
      .current_state(current_state), .title_display(title_display),
      .difficulty_display(difficulty_display), .running_display(running_display),
      .easy_selected(easy_selected), .hard_selected(hard_selected),
      .cursor_x(cursor_x), .cursor_y(cursor_y)
   );

   always #5 clk = ~clk;

   // Button vector order: {a, b, start, up, down, left, right}
   localparam logic [6:0] BN = 7'h00, BA = 7'h40, BB = 7'h20, BS = 7'h10;
   localparam logic [6:0] BU = 7'h08, BD = 7'h04, BL = 7'h02, BR = 7'h01;

   typedef struct {
      logic [6:0] btn;
      logic [2:0] st;
      logic [3:0] x;
      logic [3:0] y;
   } step_t;

   step_t sb[$];
   step_t tbl[$];
   step_t e;
   int    checks = 0;
   int    failures = 0;
   int    mgrid [9][9];

   function automatic step_t mk(input logic [6:0] b, input logic [2:0] s, input int x, input int y);
      step_t r;
      r.btn = b; r.st = s; r.x = 4'(x); r.y = 4'(y);
      return r;
   endfunction

   function automatic int solv(input int x, input int y);
      return ((y * 3 + y / 3 + x) % 9) + 1;
   endfunction

   task automatic drive(input logic [6:0] b);
      {a_button, b_button, start_button, up_button, down_button, left_button, right_button} = b;
      @(posedge clk);
      #1;
      {a_button, b_button, start_button, up_button, down_button, left_button, right_button} = '0;
   endtask

   task automatic clear_model;
      for (int x = 0; x < 9; x++)
         for (int y = 0; y < 9; y++) mgrid[x][y] = 0;
   endtask

   task automatic test_reset;
      int nz;
      reset = 1'b1;
      start_button = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      start_button = 1'b0;
      clear_model();
      checks++; if (current_state !== 3'b000) begin failures++; $display("FAIL reset_state got=%0d want=0", current_state); end
      checks++; if ({title_display, difficulty_display, running_display} !== 3'b100) begin
         failures++; $display("FAIL reset_disp got=%b want=100", {title_display, difficulty_display, running_display}); end
      checks++; if ({easy_selected, hard_selected} !== 2'b10) begin
         failures++; $display("FAIL reset_diff got=%b want=10", {easy_selected, hard_selected}); end
      checks++; if (cursor_x !== 4'd4 || cursor_y !== 4'd4) begin
         failures++; $display("FAIL reset_cursor got=(%0d,%0d) want=(4,4)", cursor_x, cursor_y); end
      nz = 0;
      for (int x = 0; x < 9; x++)
         for (int y = 0; y < 9; y++) if (dut.cell_value[x][y] !== 4'd0) nz++;
      checks++; if (nz != 0) begin failures++; $display("FAIL reset_grid nonzero_cells=%0d want=0", nz); end
   endtask

   task automatic test_startup;
      int nz;
      tbl = {};
      tbl.push_back(mk(BA, 0, 4, 4)); tbl.push_back(mk(BU, 0, 4, 4));
      tbl.push_back(mk(BS, 1, 4, 4)); tbl.push_back(mk(BD, 1, 4, 4));
      tbl.push_back(mk(BA, 2, 4, 4)); tbl.push_back(mk(BN, 3, 4, 4));
      foreach (tbl[i]) begin
         sb.push_back(tbl[i]); drive(tbl[i].btn); e = sb.pop_front(); checks++;
         if (current_state !== e.st || cursor_x !== e.x || cursor_y !== e.y || title_display !== (e.st == 3'd0)
             || difficulty_display !== (e.st == 3'd1) || running_display !== (e.st inside {3'd2, 3'd3, 3'd4})) begin
            failures++;
            $display("FAIL startup step %0d got st=%0d cur=(%0d,%0d) disp=%b%b%b want st=%0d cur=(%0d,%0d)", i, current_state,
                     cursor_x, cursor_y, title_display, difficulty_display, running_display, e.st, e.x, e.y);
         end
      end
      checks++; if ({easy_selected, hard_selected} !== 2'b01) begin
         failures++; $display("FAIL startup_hard got=%b want=01", {easy_selected, hard_selected}); end
      nz = 0;
      for (int x = 0; x < 9; x++)
         for (int y = 0; y < 9; y++) if (dut.cell_value[x][y] !== 4'd0) nz++;
      checks++; if (nz != 0) begin failures++; $display("FAIL startup_grid nonzero_cells=%0d want=0", nz); end
   endtask

   task automatic test_digit_entry;
      tbl = {};
      tbl.push_back(mk(BU, 3, 4, 3)); tbl.push_back(mk(BL, 3, 3, 3));
      tbl.push_back(mk(BA, 4, 3, 3));
      repeat (3) tbl.push_back(mk(BU, 4, 3, 3));
      tbl.push_back(mk(BA, 3, 3, 3));
      tbl.push_back(mk(BL, 3, 2, 3)); tbl.push_back(mk(BA, 4, 2, 3));
      repeat (5) tbl.push_back(mk(BU, 4, 2, 3));
      tbl.push_back(mk(BA, 3, 2, 3));
      foreach (tbl[i]) begin
         sb.push_back(tbl[i]); drive(tbl[i].btn); e = sb.pop_front(); checks++;
         if (current_state !== e.st || cursor_x !== e.x || cursor_y !== e.y || title_display !== (e.st == 3'd0)
             || difficulty_display !== (e.st == 3'd1) || running_display !== (e.st inside {3'd2, 3'd3, 3'd4})) begin
            failures++;
            $display("FAIL digit_entry step %0d got st=%0d cur=(%0d,%0d) want st=%0d cur=(%0d,%0d)", i, current_state,
                     cursor_x, cursor_y, e.st, e.x, e.y);
         end
      end
      mgrid[3][3] = 3; mgrid[2][3] = 5;
      checks++; if (dut.cell_value[3][3] !== 4'd3) begin failures++; $display("FAIL cell_3_3 got=%0d want=3", dut.cell_value[3][3]); end
      checks++; if (dut.cell_value[2][3] !== 4'd5) begin failures++; $display("FAIL cell_2_3 got=%0d want=5", dut.cell_value[2][3]); end
   endtask

   task automatic test_discard;
      tbl = {};
      tbl.push_back(mk(BU, 3, 2, 2)); tbl.push_back(mk(BA, 4, 2, 2));
      repeat (5) tbl.push_back(mk(BU, 4, 2, 2));
      tbl.push_back(mk(BL, 4, 2, 2));
      tbl.push_back(mk(BB, 3, 2, 2));
      foreach (tbl[i]) begin
         sb.push_back(tbl[i]); drive(tbl[i].btn); e = sb.pop_front(); checks++;
         if (current_state !== e.st || cursor_x !== e.x || cursor_y !== e.y || title_display !== (e.st == 3'd0)
             || difficulty_display !== (e.st == 3'd1) || running_display !== (e.st inside {3'd2, 3'd3, 3'd4})) begin
            failures++;
            $display("FAIL discard step %0d got st=%0d cur=(%0d,%0d) want st=%0d cur=(%0d,%0d)", i, current_state,
                     cursor_x, cursor_y, e.st, e.x, e.y);
         end
      end
      checks++; if (dut.cell_value[2][2] !== 4'd0) begin failures++; $display("FAIL cell_2_2 got=%0d want=0", dut.cell_value[2][2]); end
   endtask

   task automatic test_wrap_and_ignore;
      tbl = {};
      tbl.push_back(mk(BU, 3, 2, 1)); tbl.push_back(mk(BL, 3, 1, 1));
      tbl.push_back(mk(BD, 3, 1, 2)); tbl.push_back(mk(BD, 3, 1, 3));
      tbl.push_back(mk(BB, 3, 1, 3)); tbl.push_back(mk(BS, 3, 1, 3));
      tbl.push_back(mk(BL, 3, 0, 3));
      tbl.push_back(mk(BU, 3, 0, 2)); tbl.push_back(mk(BU, 3, 0, 1)); tbl.push_back(mk(BU, 3, 0, 0));
      tbl.push_back(mk(BL, 3, 8, 0)); tbl.push_back(mk(BR, 3, 0, 0));
      tbl.push_back(mk(BU, 3, 0, 8)); tbl.push_back(mk(BD, 3, 0, 0));
      // Decrement from an empty cell: 0 -> 9 -> 8
      tbl.push_back(mk(BA, 4, 0, 0)); tbl.push_back(mk(BD, 4, 0, 0)); tbl.push_back(mk(BD, 4, 0, 0));
      tbl.push_back(mk(BA, 3, 0, 0));
      // Priority: a beats up, b beats up, start beats left
      tbl.push_back(mk(BA | BU, 4, 0, 0)); tbl.push_back(mk(BB | BU, 3, 0, 0));
      tbl.push_back(mk(BS | BL, 3, 0, 0));
      foreach (tbl[i]) begin
         sb.push_back(tbl[i]); drive(tbl[i].btn); e = sb.pop_front(); checks++;
         if (current_state !== e.st || cursor_x !== e.x || cursor_y !== e.y || title_display !== (e.st == 3'd0)
             || difficulty_display !== (e.st == 3'd1) || running_display !== (e.st inside {3'd2, 3'd3, 3'd4})) begin
            failures++;
            $display("FAIL wrap step %0d got st=%0d cur=(%0d,%0d) want st=%0d cur=(%0d,%0d)", i, current_state,
                     cursor_x, cursor_y, e.st, e.x, e.y);
         end
      end
      mgrid[0][0] = 8;
      checks++; if (dut.cell_value[0][0] !== 4'd8) begin failures++; $display("FAIL cell_0_0_dec got=%0d want=8", dut.cell_value[0][0]); end
   endtask

   task automatic add_set_digit(input int x, input int y, input int v);
      int c, ups;
      c = mgrid[x][y];
      ups = (c == 0) ? v : (v - c + 9) % 9;
      tbl.push_back(mk(BA, 4, x, y));
      for (int k = 0; k < ups; k++) tbl.push_back(mk(BU, 4, x, y));
      tbl.push_back(mk(BA, 3, x, y));
      mgrid[x][y] = v;
   endtask

   task automatic test_solve;
      int bad;
      tbl = {};
      for (int y = 0; y < 9; y++) begin
         for (int x = 0; x < 9; x++) begin
            add_set_digit(x, y, solv(x, y));
            if (x < 8) tbl.push_back(mk(BR, 3, x + 1, y));
            else begin
               tbl.push_back(mk(BR, 3, 0, y));
               tbl.push_back(mk(BD, 3, 0, (y + 1) % 9));
            end
         end
      end
      // Full grid with one duplicate in row 0 must not be accepted
      add_set_digit(0, 0, solv(1, 0));
      tbl.push_back(mk(BS, 3, 0, 0));
      add_set_digit(0, 0, solv(0, 0));
      tbl.push_back(mk(BS, 5, 0, 0));
      tbl.push_back(mk(BU, 5, 0, 0));
      tbl.push_back(mk(BS, 0, 0, 0));
      foreach (tbl[i]) begin
         sb.push_back(tbl[i]); drive(tbl[i].btn); e = sb.pop_front(); checks++;
         if (current_state !== e.st || cursor_x !== e.x || cursor_y !== e.y || title_display !== (e.st == 3'd0)
             || difficulty_display !== (e.st == 3'd1) || running_display !== (e.st inside {3'd2, 3'd3, 3'd4})) begin
            failures++;
            $display("FAIL solve step %0d got st=%0d cur=(%0d,%0d) want st=%0d cur=(%0d,%0d)", i, current_state,
                     cursor_x, cursor_y, e.st, e.x, e.y);
         end
      end
      bad = 0;
      for (int x = 0; x < 9; x++)
         for (int y = 0; y < 9; y++) if (dut.cell_value[x][y] !== 4'(mgrid[x][y])) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL solve_grid_retained bad_cells=%0d want=0", bad); end
   endtask

   task automatic test_load_clears;
      int nz;
      tbl = {};
      tbl.push_back(mk(BS, 1, 0, 0)); tbl.push_back(mk(BA, 2, 0, 0));
      tbl.push_back(mk(BN, 3, 4, 4));
      tbl.push_back(mk(BR, 3, 5, 4)); tbl.push_back(mk(BA, 4, 5, 4));
      tbl.push_back(mk(BU, 4, 5, 4)); tbl.push_back(mk(BA, 3, 5, 4));
      tbl.push_back(mk(BA, 4, 5, 4));
      foreach (tbl[i]) begin
         sb.push_back(tbl[i]); drive(tbl[i].btn); e = sb.pop_front(); checks++;
         if (current_state !== e.st || cursor_x !== e.x || cursor_y !== e.y || title_display !== (e.st == 3'd0)
             || difficulty_display !== (e.st == 3'd1) || running_display !== (e.st inside {3'd2, 3'd3, 3'd4})) begin
            failures++;
            $display("FAIL load step %0d got st=%0d cur=(%0d,%0d) want st=%0d cur=(%0d,%0d)", i, current_state,
                     cursor_x, cursor_y, e.st, e.x, e.y);
         end
      end
      nz = 0;
      for (int x = 0; x < 9; x++)
         for (int y = 0; y < 9; y++) if (!(x == 5 && y == 4) && dut.cell_value[x][y] !== 4'd0) nz++;
      checks++; if (nz != 0) begin failures++; $display("FAIL load_grid_clear nonzero_cells=%0d want=0", nz); end
      checks++; if (dut.cell_value[5][4] !== 4'd1) begin failures++; $display("FAIL cell_5_4 got=%0d want=1", dut.cell_value[5][4]); end
      checks++; if (hard_selected !== 1'b1) begin failures++; $display("FAIL hard_retained got=%b want=1", hard_selected); end
   endtask

   task automatic test_midgame_reset;
      // Reset lands while in DIGIT with a button held
      test_reset();
   endtask

   task automatic test_select_easy;
      tbl = {};
      tbl.push_back(mk(BS, 1, 4, 4)); tbl.push_back(mk(BD, 1, 4, 4));
      tbl.push_back(mk(BU, 1, 4, 4)); tbl.push_back(mk(BA | BD, 2, 4, 4));
      tbl.push_back(mk(BN, 3, 4, 4));
      foreach (tbl[i]) begin
         sb.push_back(tbl[i]); drive(tbl[i].btn); e = sb.pop_front(); checks++;
         if (current_state !== e.st || cursor_x !== e.x || cursor_y !== e.y || title_display !== (e.st == 3'd0)
             || difficulty_display !== (e.st == 3'd1) || running_display !== (e.st inside {3'd2, 3'd3, 3'd4})) begin
            failures++;
            $display("FAIL select step %0d got st=%0d cur=(%0d,%0d) want st=%0d cur=(%0d,%0d)", i, current_state,
                     cursor_x, cursor_y, e.st, e.x, e.y);
         end
      end
      checks++; if ({easy_selected, hard_selected} !== 2'b10) begin
         failures++; $display("FAIL select_easy got=%b want=10", {easy_selected, hard_selected}); end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_startup();
      test_digit_entry();
      test_discard();
      test_wrap_and_ignore();
      test_solve();
      test_load_clears();
      test_midgame_reset();
      test_select_easy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
